gpr_operand_read: RTL and testbench

Decode-stage read side of the GPR write path. Holds the 32x32 general-purpose register file and accepts one writeback per cycle, carrying the data chosen by the writeback data selector. Serves two source operands (rs, rt) with EX/MEM/WB forwarding and raises a stall when a needed producer result is not ready. Registers the resolved operands into the ID/EX boundary.

---
 rtl/gpr_operand_read_pkg.sv | 37 +++
 rtl/gpr_operand_read_regfile.sv | 49 ++++
 rtl/gpr_operand_read.sv | 124 ++++++++++++
 tb/tb_gpr_operand_read.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gpr_operand_read_pkg.sv
// Shared codes for the GPR operand-read slice: forward sources, writeback selects, r0 index.
// The GPR_FORWARD_EN macro enables EX/MEM operand forwarding.
package gpr_operand_read_pkg;

  localparam int GPR_ZERO_IDX = 0;

  typedef enum logic [1:0] {
    FWD_SRC_REG = 2'd0,
    FWD_SRC_WB  = 2'd1,
    FWD_SRC_MEM = 2'd2,
    FWD_SRC_EX  = 2'd3
  } fwd_src_e;

  typedef enum logic [2:0] {
    WB_SEL_ALU  = 3'd0,
    WB_SEL_MEM  = 3'd1,
    WB_SEL_LINK = 3'd2,
    WB_SEL_HILO = 3'd3,
    WB_SEL_CP0  = 3'd4
  } wb_sel_e;

`ifdef GPR_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // Without forwarding, any EX/MEM producer blocks the read until it reaches WB.
  function automatic logic fwd_hazard(fwd_src_e src, logic ex_wvalid, logic mem_wvalid);
    fwd_hazard = 1'b0;
    if (src == FWD_SRC_EX)
      fwd_hazard = !FWD_EN || !ex_wvalid;
    else if (src == FWD_SRC_MEM)
      fwd_hazard = !FWD_EN || !mem_wvalid;
  endfunction

endpackage

// File: rtl/gpr_operand_read_regfile.sv
// 2**ADDR_W x DATA_W register file: one write port, two async read ports,
// same-cycle write-through, register 0 hardwired to zero.
module gpr_regfile
  import gpr_operand_read_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(GPR_ZERO_IDX);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != ZERO) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs[raddr_a];
    if (raddr_a == ZERO)
      rdata_a = '0;
    else if (we && waddr == raddr_a)
      rdata_a = wdata;
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if (raddr_b == ZERO)
      rdata_b = '0;
    else if (we && waddr == raddr_b)
      rdata_b = wdata;
  end

endmodule

// File: rtl/gpr_operand_read.sv
// Decode-stage GPR read: regfile, EX/MEM/WB operand resolve, hazard stall, ID/EX register.
// GPR_FORWARD_EN (undefined by default) lets EX/MEM results forward; otherwise they stall.
module gpr_operand_read
  import gpr_operand_read_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  input  logic              i_rs_used,
  input  logic              i_rt_used,
  input  logic              i_ex_we,
  input  logic [ADDR_W-1:0] i_ex_waddr,
  input  logic [DATA_W-1:0] i_ex_wdata,
  input  logic              i_ex_wvalid,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_waddr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  input  logic              i_mem_wvalid,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_waddr,
  input  logic [DATA_W-1:0] i_wb_wdata,
  input  logic              i_id_advance,
  input  logic              i_id_flush,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic              o_operand_valid
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(GPR_ZERO_IDX);

  logic [DATA_W-1:0] rf_rs, rf_rt;
  logic [DATA_W-1:0] rs_res, rt_res;
  fwd_src_e          rs_src, rt_src;
  logic              rs_haz, rt_haz;

  gpr_regfile #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (i_wb_we),
    .waddr   (i_wb_waddr),
    .wdata   (i_wb_wdata),
    .raddr_a (i_rs_addr),
    .raddr_b (i_rt_addr),
    .rdata_a (rf_rs),
    .rdata_b (rf_rt)
  );

  // Youngest matching producer wins, so an invalid EX result is never hidden by MEM/WB.
  function automatic fwd_src_e pick_src(
    logic [ADDR_W-1:0] addr,
    logic ex_we,  logic [ADDR_W-1:0] ex_waddr,
    logic mem_we, logic [ADDR_W-1:0] mem_waddr,
    logic wb_we,  logic [ADDR_W-1:0] wb_waddr
  );
    pick_src = FWD_SRC_REG;
    if (addr != ZERO) begin
      if (ex_we && ex_waddr == addr)
        pick_src = FWD_SRC_EX;
      else if (mem_we && mem_waddr == addr)
        pick_src = FWD_SRC_MEM;
      else if (wb_we && wb_waddr == addr)
        pick_src = FWD_SRC_WB;
    end
  endfunction

  always_comb begin
    rs_src = pick_src(i_rs_addr, i_ex_we, i_ex_waddr, i_mem_we, i_mem_waddr,
                      i_wb_we, i_wb_waddr);
    rt_src = pick_src(i_rt_addr, i_ex_we, i_ex_waddr, i_mem_we, i_mem_waddr,
                      i_wb_we, i_wb_waddr);
    rs_haz = fwd_hazard(rs_src, i_ex_wvalid, i_mem_wvalid);
    rt_haz = fwd_hazard(rt_src, i_ex_wvalid, i_mem_wvalid);
  end

  always_comb begin
    rs_res = rf_rs;
    unique case (rs_src)
      FWD_SRC_EX:  rs_res = i_ex_wdata;
      FWD_SRC_MEM: rs_res = i_mem_wdata;
      FWD_SRC_WB:  rs_res = i_wb_wdata;
      default:     rs_res = rf_rs;
    endcase
  end

  always_comb begin
    rt_res = rf_rt;
    unique case (rt_src)
      FWD_SRC_EX:  rt_res = i_ex_wdata;
      FWD_SRC_MEM: rt_res = i_mem_wdata;
      FWD_SRC_WB:  rt_res = i_wb_wdata;
      default:     rt_res = rf_rt;
    endcase
  end

  assign o_stall = !reset && ((i_rs_used && rs_haz) || (i_rt_used && rt_haz));

  // A stalled advance inserts a bubble but keeps the previous operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_rs_data       <= '0;
      o_rt_data       <= '0;
      o_operand_valid <= 1'b0;
    end else if (i_id_flush) begin
      o_rs_data       <= '0;
      o_rt_data       <= '0;
      o_operand_valid <= 1'b0;
    end else if (i_id_advance && o_stall) begin
      o_operand_valid <= 1'b0;
    end else if (i_id_advance) begin
      o_rs_data       <= rs_res;
      o_rt_data       <= rt_res;
      o_operand_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpr_operand_read.sv
// Scoreboard bench for gpr_operand_read; expectations follow the GPR_FORWARD_EN build setting.
module tb_gpr_operand_read;

`ifdef GPR_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr;
  logic        rs_used, rt_used;
  logic        ex_we, ex_wvalid, mem_we, mem_wvalid, wb_we;
  logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
  logic [31:0] ex_wdata, mem_wdata, wb_wdata;
  logic        id_advance, id_flush;
  logic        stall, op_valid;
  logic [31:0] rs_data, rt_data;

  gpr_operand_read #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_rs_addr       (rs_addr),
    .i_rt_addr       (rt_addr),
    .i_rs_used       (rs_used),
    .i_rt_used       (rt_used),
    .i_ex_we         (ex_we),
    .i_ex_waddr      (ex_waddr),
    .i_ex_wdata      (ex_wdata),
    .i_ex_wvalid     (ex_wvalid),
    .i_mem_we        (mem_we),
    .i_mem_waddr     (mem_waddr),
    .i_mem_wdata     (mem_wdata),
    .i_mem_wvalid    (mem_wvalid),
    .i_wb_we         (wb_we),
    .i_wb_waddr      (wb_waddr),
    .i_wb_wdata      (wb_wdata),
    .i_id_advance    (id_advance),
    .i_id_flush      (id_flush),
    .o_stall         (stall),
    .o_rs_data       (rs_data),
    .o_rt_data       (rt_data),
    .o_operand_valid (op_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    bit          is_stall;
    logic        st;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: stall entries are due in the cycle they were driven, operand entries one edge later.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.is_stall) begin
        chk({e.nm, ".stall"}, {31'd0, stall}, {31'd0, e.st});
      end else begin
        chk({e.nm, ".rs"},    rs_data, e.rs);
        chk({e.nm, ".rt"},    rt_data, e.rt);
        chk({e.nm, ".valid"}, {31'd0, op_valid}, {31'd0, e.v});
      end
    end
  end

  task automatic idle();
    rs_addr = '0; rt_addr = '0; rs_used = 0; rt_used = 0;
    ex_we = 0; ex_waddr = '0; ex_wdata = '0; ex_wvalid = 0;
    mem_we = 0; mem_waddr = '0; mem_wdata = '0; mem_wvalid = 0;
    wb_we = 0; wb_waddr = '0; wb_wdata = '0;
    id_advance = 0; id_flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_cyc(string nm, logic st, logic [31:0] rs, logic [31:0] rt, logic v);
    exp_t s, d;
    s = '{due: cyc,     is_stall: 1'b1, st: st,   rs: '0, rt: '0, v: 1'b0, nm: nm};
    d = '{due: cyc + 1, is_stall: 1'b0, st: 1'b0, rs: rs, rt: rt, v: v,    nm: nm};
    sb.push_back(s);
    sb.push_back(d);
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // Hazard inputs while in reset: stall must stay low.
    step();
    rs_addr = 5; rt_addr = 6; rs_used = 1; rt_used = 1;
    ex_we = 1; ex_waddr = 5; ex_wvalid = 0; id_advance = 1;
    expect_cyc("reset", 0, 32'h0, 32'h0, 0);

    step(); reset = 1'b0;
    rs_addr = 5; rt_addr = 6; rs_used = 1; rt_used = 1;
    expect_cyc("post_reset_read", 0, 32'h0, 32'h0, 0);

    step();
    wb_we = 1; wb_waddr = 3; wb_wdata = 32'h12345678;
    rs_addr = 3; rs_used = 1; id_advance = 1;
    expect_cyc("wb_write_through", 0, 32'h12345678, 32'h0, 1);

    step();
    rs_addr = 3; rt_addr = 3; rs_used = 1; rt_used = 1; id_advance = 1;
    expect_cyc("regfile_read", 0, 32'h12345678, 32'h12345678, 1);

    step();
    ex_we = 1; ex_waddr = 7; ex_wdata = 32'hA5A5A5A5; ex_wvalid = 1;
    mem_we = 1; mem_waddr = 7; mem_wdata = 32'h11111111; mem_wvalid = 1;
    rs_addr = 7; rt_addr = 3; rs_used = 1; rt_used = 1; id_advance = 1;
    expect_cyc("ex_wins", !FWD, FWD ? 32'hA5A5A5A5 : 32'h12345678, 32'h12345678, FWD);

    step();
    ex_we = 1; ex_waddr = 9; ex_wvalid = 0;
    rs_addr = 3; rt_addr = 9; rs_used = 1; rt_used = 1; id_advance = 1;
    expect_cyc("load_use", 1, FWD ? 32'hA5A5A5A5 : 32'h12345678, 32'h12345678, 0);

    step();
    mem_we = 1; mem_waddr = 9; mem_wdata = 32'hDEADBEEF; mem_wvalid = 1;
    rs_addr = 3; rt_addr = 9; rs_used = 1; rt_used = 1; id_advance = 1;
    if (FWD) expect_cyc("mem_fwd", 0, 32'h12345678, 32'hDEADBEEF, 1);
    else     expect_cyc("mem_fwd", 1, 32'h12345678, 32'h12345678, 0);

    step();
    wb_we = 1; wb_waddr = 0; wb_wdata = 32'hFFFFFFFF;
    ex_we = 1; ex_waddr = 0; ex_wvalid = 0;
    rs_addr = 0; rt_addr = 0; rs_used = 1; rt_used = 1; id_advance = 1;
    expect_cyc("r0_hardwire", 0, 32'h0, 32'h0, 1);

    step();
    ex_we = 1; ex_waddr = 10; ex_wvalid = 0;
    mem_we = 1; mem_waddr = 10; mem_wdata = 32'h55; mem_wvalid = 1;
    rs_addr = 10; rs_used = 1; id_advance = 1;
    expect_cyc("young_invalid_masks", 1, 32'h0, 32'h0, 0);

    step();
    ex_we = 1; ex_waddr = 11; ex_wvalid = 0;
    rs_addr = 11; rs_used = 0; rt_addr = 3; rt_used = 1; id_advance = 1;
    expect_cyc("unused_hazard", 0, 32'h0, 32'h12345678, 1);

    // r4 producer walks EX -> MEM -> WB.
    step();
    ex_we = 1; ex_waddr = 4; ex_wdata = 32'h44; ex_wvalid = 1;
    rs_addr = 4; rs_used = 1; id_advance = 1;
    if (FWD) expect_cyc("r4_ex", 0, 32'h44, 32'h0, 1);
    else     expect_cyc("r4_ex", 1, 32'h0, 32'h12345678, 0);

    step();
    mem_we = 1; mem_waddr = 4; mem_wdata = 32'h44; mem_wvalid = 1;
    rs_addr = 4; rs_used = 1; id_advance = 1;
    if (FWD) expect_cyc("r4_mem", 0, 32'h44, 32'h0, 1);
    else     expect_cyc("r4_mem", 1, 32'h0, 32'h12345678, 0);

    step();
    wb_we = 1; wb_waddr = 4; wb_wdata = 32'h44;
    rs_addr = 4; rs_used = 1; id_advance = 1;
    expect_cyc("r4_wb", 0, 32'h44, 32'h0, 1);

    step();
    rs_addr = 3; rs_used = 1; id_advance = 1; id_flush = 1;
    expect_cyc("flush", 0, 32'h0, 32'h0, 0);

    step();
    rs_addr = 3; rs_used = 1; id_advance = 1;
    expect_cyc("reload", 0, 32'h12345678, 32'h0, 1);

    step();
    rs_addr = 4; rs_used = 1; id_advance = 0;
    expect_cyc("hold", 0, 32'h12345678, 32'h0, 1);

    step(); reset = 1'b1;
    ex_we = 1; ex_waddr = 9; ex_wvalid = 0;
    rt_addr = 9; rt_used = 1; id_advance = 1;
    expect_cyc("reset_mid_stall", 0, 32'h0, 32'h0, 0);

    step(); reset = 1'b0;
    rs_addr = 3; rt_addr = 4; rs_used = 1; rt_used = 1; id_advance = 1;
    expect_cyc("regs_cleared", 0, 32'h0, 32'h0, 1);

    step();
    repeat (3) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
